// File: rtl/simon_frame_ctrl.sv
// Frame sequencer between the UART FIFOs and an iterative SIMON64/96 core:
// pops CMD/key/text bytes, runs one cipher operation, pushes the result bytes.
module simon_frame_ctrl #(
   parameter int KEY_BYTES   = 12,
   parameter int BLK_BYTES   = 8,
   parameter int TIMEOUT_CYC = 10_000_000
) (
   input  logic                   clk_100MHz,
   input  logic                   reset,
   input  logic                   rx_empty,
   input  logic [7:0]             rx_data,
   output logic                   rd_uart,
   input  logic                   tx_full,
   output logic                   wr_uart,
   output logic [7:0]             wr_data,
   output logic                   cipher_start,
   output logic                   cipher_mode,
   output logic [8*KEY_BYTES-1:0] cipher_key,
   output logic [8*BLK_BYTES-1:0] cipher_text,
   input  logic                   cipher_done,
   input  logic [8*BLK_BYTES-1:0] cipher_result,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   frame_err,
   output logic [15:0]            frame_cnt
);

   localparam int KW    = 8 * KEY_BYTES;
   localparam int BW    = 8 * BLK_BYTES;
   localparam int CNT_W = $clog2((KEY_BYTES > BLK_BYTES ? KEY_BYTES : BLK_BYTES) + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
   localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_BYTES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]       CMD_ENC  = 8'h45;
   localparam logic [7:0]       CMD_DEC  = 8'h44;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_KEY,
      S_LOAD_TEXT,
      S_START,
      S_WAIT,
      S_SEND
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [KW-1:0]    key_q, key_d;
   logic [BW-1:0]    text_q, text_d;
   logic [BW-1:0]    res_q, res_d;
   logic             mode_q, mode_d;
   logic             start_q, start_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [15:0]      fcnt_q, fcnt_d;
   logic             pop, push;

   // Strobes are combinational so a FIFO byte moves in the same cycle it is offered.
   assign pop  = !rx_empty && (state_q inside {S_IDLE, S_LOAD_KEY, S_LOAD_TEXT});
   assign push = !tx_full && (state_q == S_SEND);

   assign rd_uart      = pop;
   assign wr_uart      = push;
   assign wr_data      = res_q[BW-1 -: 8];
   assign cipher_start = start_q;
   assign cipher_mode  = mode_q;
   assign cipher_key   = key_q;
   assign cipher_text  = text_q;
   assign busy         = (state_q != S_IDLE);
   assign frame_done   = done_q;
   assign frame_err    = err_q;
   assign frame_cnt    = fcnt_q;

   always_comb begin
      // NOTE: every _d defaults to its _q (pulses to 0) so no path through the case infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      key_d   = key_q;
      text_d  = text_q;
      res_d   = res_q;
      mode_d  = mode_q;
      start_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      fcnt_d  = fcnt_q;

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               if (rx_data == CMD_ENC || rx_data == CMD_DEC) begin
                  mode_d  = (rx_data == CMD_ENC);
                  cnt_d   = '0;
                  tmo_d   = '0;
                  state_d = S_LOAD_KEY;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_LOAD_KEY: begin
            if (pop) begin
               key_d = {key_q[KW-9:0], rx_data};
               tmo_d = '0;
               if (cnt_q == KEY_LAST) begin
                  cnt_d   = '0;
                  state_d = S_LOAD_TEXT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               tmo_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         S_LOAD_TEXT: begin
            if (pop) begin
               text_d = {text_q[BW-9:0], rx_data};
               tmo_d  = '0;
               if (cnt_q == BLK_LAST) begin
                  cnt_d   = '0;
                  start_d = 1'b1;
                  state_d = S_START;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               tmo_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         S_START: state_d = S_WAIT;

         S_WAIT: begin
            if (cipher_done) begin
               res_d   = cipher_result;
               cnt_d   = '0;
               state_d = S_SEND;
            end
         end

         S_SEND: begin
            if (push) begin
               res_d = {res_q[BW-9:0], 8'h00};
               if (cnt_q == BLK_LAST) begin
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  fcnt_d  = fcnt_q + 16'd1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the wide data registers are reset too, because they drive the core ports directly.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         key_q   <= '0;
         text_q  <= '0;
         res_q   <= '0;
         mode_q  <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         // NOTE: non-blocking only; all ordering-sensitive work is already done in the _d logic.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         key_q   <= key_d;
         text_q  <= text_d;
         res_q   <= res_d;
         mode_q  <= mode_d;
         start_q <= start_d;
         done_q  <= done_d;
         err_q   <= err_d;
         fcnt_q  <= fcnt_d;
      end
   end

endmodule
